// File: rtl/fhe_alu_pkg.sv
// rtl/fhe_alu_pkg.sv - shared Benes switch geometry, route-config type and scheduler states
package fhe_alu_pkg;

  localparam int SWITCH_NUM = 4;
  localparam int STAGE_NUM  = 5;

  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] sel_arr_t;

  typedef struct packed {
    sel_arr_t module_sel;
    sel_arr_t slot_sel;
  } benes_cfg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at the caller-held pointer
module rr_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int PTR_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [REQ_NUM-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = PTR_W'((int'(ptr) + i) % REQ_NUM);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/benes_route_sched.sv
// rtl/benes_route_sched.sv - schedules requesters onto a Benes interconnect path from a config table
module benes_route_sched
  import fhe_alu_pkg::*;
#(
  parameter int REQ_NUM      = 4,
  parameter int CFG_DEPTH    = 16,
  parameter int LEN_W        = 8,
  parameter int INTC_LATENCY = 6
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_we,
  input  logic [$clog2(CFG_DEPTH)-1:0]                  cfg_addr,
  input  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]          cfg_module_sel,
  input  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]          cfg_slot_sel,
  input  logic [REQ_NUM-1:0]                            i_req_valid,
  input  logic [REQ_NUM-1:0][$clog2(CFG_DEPTH)-1:0]     i_req_cfg_idx,
  input  logic [REQ_NUM-1:0][LEN_W-1:0]                 i_req_len,
  output logic [REQ_NUM-1:0]                            o_req_ready,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]          o_module_select,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]          o_slot_select,
  output logic                                          o_xfer_en,
  output logic [$clog2(REQ_NUM)-1:0]                    o_owner,
  output logic                                          o_busy,
  output logic                                          o_done
);

  localparam int IDX_W = $clog2(CFG_DEPTH);
  localparam int PTR_W = $clog2(REQ_NUM);
  localparam int DRN_W = $clog2(INTC_LATENCY + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_DRAIN  = DRAIN;

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LEN_W-1:0]   len_cnt;
  logic [DRN_W-1:0]   drn_cnt;
  logic               recover;
  benes_cfg_t         sel_q;
  benes_cfg_t         cfg_table [CFG_DEPTH];

  logic [REQ_NUM-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_winner;
  logic               arb_any;
  logic               grant_fire;

  rr_arbiter #(
    .REQ_NUM (REQ_NUM),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req    (i_req_valid),
    .ptr    (ptr),
    .grant  (arb_grant),
    .winner (arb_winner),
    .any    (arb_any)
  );

  // One bubble cycle in IDLE after a release keeps the grant-to-grant spacing fixed.
  assign grant_fire = !rst && (state == ST_IDLE) && !recover && arb_any;

  assign o_req_ready     = grant_fire ? arb_grant : '0;
  assign o_module_select = sel_q.module_sel;
  assign o_slot_select   = sel_q.slot_sel;
  assign o_xfer_en       = (state == ST_ACTIVE);
  assign o_busy          = (state != ST_IDLE);
  assign o_done          = (state == ST_DRAIN) && (drn_cnt == '0);
  assign o_owner         = (state == ST_IDLE) ? '0 : owner_q;

  // Table is deliberately left out of reset so config survives a scheduler reset.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      cfg_table[cfg_addr] <= {cfg_module_sel, cfg_slot_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      owner_q <= '0;
      idx_q   <= '0;
      len_cnt <= '0;
      drn_cnt <= '0;
      recover <= 1'b0;
      sel_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          recover <= 1'b0;
          if (grant_fire) begin
            owner_q <= arb_winner;
            idx_q   <= i_req_cfg_idx[arb_winner];
            len_cnt <= i_req_len[arb_winner];
            ptr     <= PTR_W'((int'(arb_winner) + 1) % REQ_NUM);
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          sel_q <= cfg_table[idx_q];
          state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (len_cnt == '0) begin
            drn_cnt <= DRN_W'(INTC_LATENCY - 1);
            state   <= ST_DRAIN;
          end else begin
            len_cnt <= len_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drn_cnt == '0) begin
            recover <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            drn_cnt <= drn_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
